// File: rtl/csa_final_adder.sv
// csa_final_adder: final carry-propagate stage behind a Wallace-tree reduction.
// Resolves the carry-save pair (sum_vec, carry_vec) into a binary product,
// CHUNK bits per cycle, with valid/ready handshakes on both sides.
// Optional macro CSA_FINAL_EARLY_EXIT_EN: finish as soon as the remaining
// upper chunks are all zero and no carry is pending.
module csa_final_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("csa_final_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] product_reg;
  logic [WIDTH-1:0] product_next;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             overflow_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic             busy_reg;

  int               chunk_base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_carry;

  // Product bits to clear when the operation finishes early.
  logic [WIDTH-1:0] clear_mask;
  logic             early_exit;

  // One CHUNK-wide slice of the carry-propagate add, selected by idx_reg.
  always_comb begin
    chunk_base = int'(idx_reg) * CHUNK;
    a_chunk    = a_reg[chunk_base +: CHUNK];
    b_chunk    = b_reg[chunk_base +: CHUNK];
    {chunk_carry, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                             + (CHUNK + 1)'(carry_reg);
  end

`ifdef CSA_FINAL_EARLY_EXIT_EN
  logic [NCHUNK-1:0] chunk_zero;
  logic              upper_zero;
  logic [WIDTH-1:0]  upper_mask;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk_zero
      assign chunk_zero[gi] = ~|a_reg[gi*CHUNK +: CHUNK] & ~|b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Are all chunks above the current one zero in both operands?
  always_comb begin
    upper_zero = 1'b1;
    upper_mask = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (k > int'(idx_reg)) begin
        if (!chunk_zero[k]) upper_zero = 1'b0;
        upper_mask[k*CHUNK +: CHUNK] = '1;
      end
    end
  end

  // Gate on the carry out of this chunk (not just the incoming carry) so a
  // carry rippling into an all-zero upper region is never dropped.
  assign early_exit = (state_reg == ADD) && !chunk_carry && upper_zero;
  assign clear_mask = early_exit ? upper_mask : '0;
`else
  assign early_exit = 1'b0;
  assign clear_mask = '0;
`endif

  // Next product: current chunk written in place, upper chunks cleared on early exit.
  always_comb begin
    product_next = product_reg & ~clear_mask;
    product_next[chunk_base +: CHUNK] = chunk_sum;
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      product_reg   <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= sum_vec;
            b_reg        <= carry_vec;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ADD;
          end
        end
        ADD: begin
          product_reg <= product_next;
          carry_reg   <= chunk_carry;
          idx_reg     <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX || early_exit) begin
            overflow_reg  <= early_exit ? 1'b0 : chunk_carry;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign overflow  = overflow_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_csa_final_adder.sv
// Directed testbench for csa_final_adder (WIDTH=16, CHUNK=4).
// Latency expectations follow CSA_FINAL_EARLY_EXIT_EN when it is defined.
module tb_csa_final_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_vec;
  logic [15:0] carry_vec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        overflow;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  csa_final_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present one operand pair, then wait for out_valid.
  // lat = cycles from accept edge to out_valid, or -1 on timeout.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    sum_vec   = a;
    carry_vec = b;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    $display("txn a=%h b=%h product=%h overflow=%b latency=%0d", a, b, product, overflow, lat);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("FAIL reset_product got=%h want=0000", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  // 255 x 255: check per-cycle handshake timing across ADD and DONE.
  task automatic test_basic;
    sum_vec   = 16'hFE00;
    carry_vec = 16'h0001;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_add%0d got=%b want=0", i, in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_out_valid_early%0d got=%b want=0", i, out_valid); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_add%0d got=%b want=1", i, busy); end
      tick();
    end
    $display("txn a=fe00 b=0001 product=%h overflow=%b", product, overflow);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_done got=%b want=0", in_ready); end
    vectors++; if (product !== 16'hFE01) begin miscompares++; $display("FAIL basic_product got=%h want=fe01", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_overflow got=%b want=0", overflow); end
    release_out();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_out_valid_clear got=%b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_ripple;
    logic [15:0] a_tab [3];
    logic [15:0] b_tab [3];
    logic [15:0] p_tab [3];
    logic        o_tab [3];
    int lat;
    a_tab = '{16'h0FFF, 16'hFFFF, 16'hFFFF};
    b_tab = '{16'h0001, 16'h0001, 16'hFFFF};
    p_tab = '{16'h1000, 16'h0000, 16'hFFFE};
    o_tab = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(a_tab[i], b_tab[i], lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL ripple%0d_latency got=%0d want=4", i, lat); end
      vectors++; if (product !== p_tab[i]) begin miscompares++; $display("FAIL ripple%0d_product got=%h want=%h", i, product, p_tab[i]); end
      vectors++; if (overflow !== o_tab[i]) begin miscompares++; $display("FAIL ripple%0d_overflow got=%b want=%b", i, overflow, o_tab[i]); end
      release_out();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    do_op(16'h1234, 16'h0101, lat);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid%0d got=%b want=1", i, out_valid); end
      vectors++; if (product !== 16'h1335) begin miscompares++; $display("FAIL bp_product%0d got=%h want=1335", i, product); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL bp_overflow%0d got=%b want=0", i, overflow); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready%0d got=%b want=0", i, in_ready); end
      // A stray request while the result is pending must be ignored.
      if (i == 1) begin
        sum_vec   = 16'hFFFF;
        carry_vec = 16'hFFFF;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    release_out();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    vectors++; if (product !== 16'h1335) begin miscompares++; $display("FAIL bp_product_hold got=%h want=1335", product); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_ignored_req_busy got=%b want=0", busy); end
  endtask

  task automatic test_latency;
    int lat;
    int want_lat;
`ifdef CSA_FINAL_EARLY_EXIT_EN
    want_lat = 1;
`else
    want_lat = 4;
`endif
    do_op(16'h0003, 16'h0004, lat);
    vectors++; if (lat !== want_lat) begin miscompares++; $display("FAIL small_latency got=%0d want=%0d", lat, want_lat); end
    vectors++; if (product !== 16'h0007) begin miscompares++; $display("FAIL small_product got=%h want=0007", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL small_overflow got=%b want=0", overflow); end
    release_out();
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_p [$];
    logic        exp_o [$];
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] s;
    logic [15:0] ep;
    logic        eo;
    int sent, got, cyc, last_cyc;
    sent = 0; got = 0; cyc = 0; last_cyc = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 20 && cyc < 400) begin
      if (out_valid) begin
        if (exp_p.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b2b_unexpected_out_valid got=1 want=0 cycle=%0d", cyc);
        end else begin
          ep = exp_p.pop_front();
          eo = exp_o.pop_front();
          $display("txn b2b %0d product=%h overflow=%b cycle=%0d", got, product, overflow, cyc);
          vectors++; if (product !== ep) begin miscompares++; $display("FAIL b2b%0d_product got=%h want=%h", got, product, ep); end
          vectors++; if (overflow !== eo) begin miscompares++; $display("FAIL b2b%0d_overflow got=%b want=%b", got, overflow, eo); end
          if (last_cyc >= 0) begin
            vectors++; if (cyc - last_cyc !== 6) begin miscompares++; $display("FAIL b2b%0d_spacing got=%0d want=6", got, cyc - last_cyc); end
          end
          last_cyc = cyc;
        end
        got++;
      end
      if (in_ready && sent < 20) begin
        // Top nibble forced nonzero so latency is the full 4 cycles in every build.
        a = 16'($urandom) | 16'h1000;
        b = 16'($urandom) | 16'h1000;
        sum_vec   = a;
        carry_vec = b;
        s = {1'b0, a} + {1'b0, b};
        exp_p.push_back(s[15:0]);
        exp_o.push_back(s[16]);
        sent++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (got !== 20) begin miscompares++; $display("FAIL b2b_result_count got=%0d want=20", got); end
  endtask

  task automatic test_reset_mid_add;
    int lat;
    sum_vec   = 16'hFFFF;
    carry_vec = 16'h0001;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("FAIL midrst_product got=%h want=0000", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_overflow got=%b want=0", overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_out_valid%0d got=%b want=0", i, out_valid); end
    end
    do_op(16'h00FF, 16'h0F01, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL midrst_fresh_latency got=%0d want=4", lat); end
    vectors++; if (product !== 16'h1000) begin miscompares++; $display("FAIL midrst_fresh_product got=%h want=1000", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_fresh_overflow got=%b want=0", overflow); end
    release_out();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_vec   = '0;
    carry_vec = '0;
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_latency();
    test_back_to_back();
    test_reset_mid_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
